wash_cycle_timer: RTL and testbench

- Elapsed-minute timer feeding the washing-machine controller FSM.
- Divides clk into one-minute ticks and counts whole minutes on the 5-bit `timer` bus, which the controller compares against its phase-end constants.
- Counts only while the controller asserts `timer_enable`, and freezes while the controller asserts `pause_flag`.
- Clears to zero whenever the controller returns to idle.

---
 rtl/washer_pkg.sv | 20 ++
 rtl/minute_prescaler.sv | 30 +++
 rtl/wash_cycle_timer.sv | 112 +++++++++++
 tb/tb_wash_cycle_timer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared washer definitions: timer state encoding, timer width/limit and the
// controller phase-end minute constants.
package washer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  localparam int TIMER_W = 5;
  localparam logic [TIMER_W-1:0] TIMER_MAX = 5'd31;

  // Phase-end minutes the controller compares against `timer`.
  localparam logic [TIMER_W-1:0] FILL_END_MIN  = 5'd3;
  localparam logic [TIMER_W-1:0] WASH_END_MIN  = 5'd15;
  localparam logic [TIMER_W-1:0] RINSE_END_MIN = 5'd22;
  localparam logic [TIMER_W-1:0] SPIN_END_MIN  = 5'd28;

endpackage

// File: rtl/minute_prescaler.sv
// Clock-to-minute prescaler: counts run cycles and flags the terminal count
// (prescaler == LIMIT-1) combinationally so the owner can act on that edge.
module minute_prescaler #(
  parameter int LIMIT   = 60000000,
  parameter int PRESC_W = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tc
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(LIMIT - 1);

  logic [PRESC_W-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (run) begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

  assign tc = run && (presc == LAST);

endmodule

// File: rtl/wash_cycle_timer.sv
// Elapsed-minute timer for the washer controller. Define TIMER_FAST_SIM_EN to
// shorten a "minute" to FAST_CYCLES clocks for simulation or FPGA demos.
//
// state | meaning
// IDLE  | controller idle; timer, prescaler and saturation cleared
// RUN   | counting clocks toward the next whole minute
// HOLD  | paused; prescaler and timer frozen
module wash_cycle_timer
  import washer_pkg::*;
#(
  parameter int CYCLES_PER_MIN = 60000000,
  parameter int PRESC_W        = 26,
  parameter int FAST_CYCLES    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               timer_enable,
  input  logic               pause_flag,
  output logic [TIMER_W-1:0] timer,
  output logic               minute_tick,
  output logic               paused,
  output logic               timer_sat
);

`ifdef TIMER_FAST_SIM_EN
  localparam int LIMIT = FAST_CYCLES;
`else
  localparam int LIMIT = CYCLES_PER_MIN;
`endif

  if (CYCLES_PER_MIN < 2 || FAST_CYCLES < 2 ||
      (64'(1) << PRESC_W) < 64'(CYCLES_PER_MIN)) begin : g_bad_param
    $error("wash_cycle_timer: illegal prescaler parameters");
  end

  timer_state_t state;
  logic         tc;
  logic         presc_clr;
  logic         presc_run;

  // Pause and enable drop both take effect on this edge, so the prescaler
  // must not advance in the cycle they are seen.
  assign presc_clr = (state == IDLE) || !timer_enable;
  assign presc_run = (state == RUN) && timer_enable && !pause_flag;

  minute_prescaler #(
    .LIMIT   (LIMIT),
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .run   (presc_run),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      minute_tick <= 1'b0;
      paused      <= 1'b0;
      timer_sat   <= 1'b0;
    end else begin
      minute_tick <= 1'b0;
      case (state)
        IDLE: begin
          timer     <= '0;
          timer_sat <= 1'b0;
          if (timer_enable) begin
            state  <= pause_flag ? HOLD : RUN;
            paused <= pause_flag;
          end else begin
            paused <= 1'b0;
          end
        end
        RUN: begin
          if (!timer_enable) begin
            state     <= IDLE;
            timer     <= '0;
            timer_sat <= 1'b0;
            paused    <= 1'b0;
          end else if (pause_flag) begin
            state  <= HOLD;
            paused <= 1'b1;
          end else if (tc && timer != TIMER_MAX) begin
            timer       <= timer + 1'b1;
            minute_tick <= 1'b1;
            if (timer == TIMER_MAX - 1'b1) timer_sat <= 1'b1;
          end
        end
        HOLD: begin
          if (!timer_enable) begin
            state     <= IDLE;
            timer     <= '0;
            timer_sat <= 1'b0;
            paused    <= 1'b0;
          end else if (!pause_flag) begin
            state  <= RUN;
            paused <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= '0;
          paused <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Directed bench for wash_cycle_timer with a 4-clock minute, so the expected
// tick positions below are counted by hand in clock edges.
module tb_wash_cycle_timer;

  logic       clk;
  logic       rst_n;
  logic       timer_enable;
  logic       pause_flag;
  logic [4:0] timer;
  logic       minute_tick;
  logic       paused;
  logic       timer_sat;

  int errors = 0;
  int checks = 0;

  wash_cycle_timer #(
    .CYCLES_PER_MIN (4),
    .PRESC_W        (26),
    .FAST_CYCLES    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .timer_enable (timer_enable),
    .pause_flag   (pause_flag),
    .timer        (timer),
    .minute_tick  (minute_tick),
    .paused       (paused),
    .timer_sat    (timer_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit tick_seen;
    rst_n        = 1'b0;
    timer_enable = 1'b1;
    pause_flag   = 1'b0;
    #23;
    check("rst_timer", timer, 0);
    check("rst_tick", minute_tick, 0);
    check("rst_paused", paused, 0);
    check("rst_sat", timer_sat, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic counting: ticks on edges 4, 8, 12 after entering RUN.
    step(1);                                  // IDLE -> RUN, prescaler 0
    step(3);
    check("run_pre_tick", minute_tick, 0);
    check("run_pre_timer", timer, 0);
    step(1);
    check("run_tick1", minute_tick, 1);
    check("run_timer1", timer, 1);
    step(1);
    check("run_tick_pulse", minute_tick, 0);
    step(3);
    check("run_timer2", timer, 2);
    check("run_tick2", minute_tick, 1);
    step(4);
    check("run_timer3", timer, 3);        // prescaler now 0

    // Pause with prescaler at 2 for 10 cycles.
    step(2);
    pause_flag = 1'b1;
    tick_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("hold_paused", paused, 1);
      if (minute_tick) tick_seen = 1'b1;
    end
    check("hold_timer", timer, 3);
    check("hold_no_tick", tick_seen, 0);
    pause_flag = 1'b0;
    step(1);
    check("release_paused", paused, 0);
    check("release_tick0", minute_tick, 0);
    step(1);
    check("release_tick1", minute_tick, 0);
    step(1);
    check("resume_tick", minute_tick, 1);
    check("resume_timer", timer, 4);       // prescaler now 0

    // Pause raised on the terminal-count cycle: pause wins.
    step(3);                                  // prescaler 3
    pause_flag = 1'b1;
    step(1);
    check("coll_no_tick", minute_tick, 0);
    check("coll_timer", timer, 4);
    check("coll_paused", paused, 1);
    pause_flag = 1'b0;
    step(1);
    check("coll_release_tick", minute_tick, 0);
    step(1);
    check("coll_tick", minute_tick, 1);
    check("coll_timer5", timer, 5);

    // Enable drop coinciding with terminal count: clear wins.
    step(3);                                  // prescaler 3, timer 5
    timer_enable = 1'b0;
    step(1);
    check("drop_timer", timer, 0);
    check("drop_tick", minute_tick, 0);
    step(1);
    check("idle_timer", timer, 0);

    // Re-enable with pause held enters HOLD directly.
    timer_enable = 1'b1;
    pause_flag   = 1'b1;
    step(1);
    check("idle_to_hold", paused, 1);
    pause_flag = 1'b0;
    step(1);                                  // HOLD -> RUN, prescaler 0
    check("hold_to_run", paused, 0);
    step(3);
    check("reen_no_tick", minute_tick, 0);
    step(1);
    check("reen_tick", minute_tick, 1);
    check("reen_timer", timer, 1);

    // Saturation at 31.
    step(116);
    check("sat_timer30", timer, 30);
    check("sat_not_yet", timer_sat, 0);
    step(4);
    check("sat_timer31", timer, 31);
    check("sat_tick31", minute_tick, 1);
    check("sat_set", timer_sat, 1);
    tick_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (minute_tick) tick_seen = 1'b1;
    end
    check("sat_no_more_ticks", tick_seen, 0);
    check("sat_hold_timer", timer, 31);
    check("sat_sticky", timer_sat, 1);
    timer_enable = 1'b0;
    step(1);
    check("sat_clear", timer_sat, 0);
    check("sat_clear_timer", timer, 0);

    // Asynchronous reset mid-RUN at timer 7.
    timer_enable = 1'b1;
    step(1);                                  // IDLE -> RUN
    step(28);
    check("pre_rst_timer7", timer, 7);
    step(2);
    rst_n = 1'b0;
    #1;
    check("arst_timer", timer, 0);
    check("arst_tick", minute_tick, 0);
    check("arst_sat", timer_sat, 0);
    check("arst_paused", paused, 0);
    step(2);
    rst_n = 1'b1;
    step(1);                                  // IDLE -> RUN
    step(3);
    check("post_rst_no_tick", minute_tick, 0);
    step(1);
    check("post_rst_tick", minute_tick, 1);
    check("post_rst_timer", timer, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
